// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq_ctrl instruction sequencer.
// Optional busy-cycle counter is enabled by ALU_SEQ_CYCLE_CNT_EN (see alu_seq_ctrl).
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_MOV_IMM = 2'd1,
    CLS_MOV_REG = 2'd2,
    CLS_ILLEGAL = 2'd3
  } cls_t;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction-field decode for alu_seq_ctrl: class, CMP flag,
// whether the A operand and a writeback are needed, and the sign-extended immediate.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [15:0]  ir,
  output cls_t         cls,
  output logic         is_cmp,
  output logic         needs_a,
  output logic         needs_write,
  output logic [W-1:0] sximm8
);

  // Register numbers are consumed by the datapath, not by this controller.
  logic unused_rn;
  assign unused_rn = ^ir[10:8];

  always_comb begin
    cls = CLS_ILLEGAL;
    if (ir[15:13] == OPC_ALU) begin
      cls = CLS_ALU;
    end else if (ir[15:13] == OPC_MOV) begin
      if (ir[12:11] == MOV_IMM)
        cls = CLS_MOV_IMM;
      else if (ir[12:11] == MOV_REG)
        cls = CLS_MOV_REG;
    end
    is_cmp      = (cls == CLS_ALU) && (ir[12:11] == ALU_SUB);
    needs_a     = (cls == CLS_ALU) && (ir[12:11] != ALU_NOTB);
    needs_write = (cls != CLS_ILLEGAL) && !is_cmp;
  end

  assign sximm8 = {{(W-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM sequencing register read, execute, status and writeback strobes.
// Define ALU_SEQ_CYCLE_CNT_EN to add the saturating busy_cycles counter output.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  instr,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [2:0]   nsel,
  output logic         loada,
  output logic         loadb,
  output logic         asel,
  output logic         loadc,
  output logic         loads,
  output logic         write,
  output logic         vsel,
  output logic [1:0]   alu_op,
  output logic [1:0]   shift,
  output logic [W-1:0] sximm8,
  output logic         done,
  output logic         err
`ifdef ALU_SEQ_CYCLE_CNT_EN
  , output logic [15:0] busy_cycles
`endif
);

  state_t       state, state_n;
  logic [15:0]  ir, ir_n;
  cls_t         cls;
  logic         is_cmp, needs_a, needs_write;
  logic [W-1:0] sx_n;

  logic         ready_n, loada_n, loadb_n, asel_n, loadc_n, loads_n;
  logic         write_n, vsel_n, done_n, err_n;
  logic [2:0]   nsel_n;
  logic [1:0]   alu_op_n, shift_n;

  // Decoding the next IR lets every Moore output be registered one cycle early.
  alu_seq_decode #(.W(W)) u_decode (
    .ir          (ir_n),
    .cls         (cls),
    .is_cmp      (is_cmp),
    .needs_a     (needs_a),
    .needs_write (needs_write),
    .sximm8      (sx_n)
  );

  always_comb begin
    ir_n = ir;
    if (state == S_IDLE && in_valid)
      ir_n = instr;
  end

  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          case (cls)
            CLS_ALU:     state_n = needs_a ? S_GET_A : S_GET_B;
            CLS_MOV_REG: state_n = S_GET_B;
            CLS_MOV_IMM: state_n = S_WRITE;
            default:     state_n = S_ERR;
          endcase
        end
      end
      S_GET_A: state_n = S_GET_B;
      S_GET_B: state_n = S_EXEC;
      S_EXEC:  state_n = needs_write ? S_WRITE : S_IDLE;
      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n == S_IDLE);
    loada_n = (state_n == S_GET_A);
    loadb_n = (state_n == S_GET_B);
    asel_n  = (state_n == S_EXEC) && (cls == CLS_MOV_REG);
    loadc_n = (state_n == S_EXEC) && !is_cmp;
    loads_n = (state_n == S_EXEC) && is_cmp;
    write_n = (state_n == S_WRITE);
    vsel_n  = (state_n == S_WRITE) && (cls == CLS_MOV_IMM);
    done_n  = (state_n == S_WRITE) || ((state_n == S_EXEC) && is_cmp);
    err_n   = (state_n == S_ERR);

    case (state_n)
      S_GET_A: nsel_n = NSEL_RN;
      S_GET_B: nsel_n = NSEL_RM;
      S_WRITE: nsel_n = (cls == CLS_MOV_IMM) ? NSEL_RN : NSEL_RD;
      default: nsel_n = NSEL_NONE;
    endcase

    alu_op_n = (cls == CLS_ALU) ? ir_n[12:11] : ALU_ADD;
    shift_n  = (cls == CLS_ALU || cls == CLS_MOV_REG) ? ir_n[4:3] : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= '0;
      in_ready <= 1'b1;
      nsel     <= '0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      write    <= 1'b0;
      vsel     <= 1'b0;
      alu_op   <= '0;
      shift    <= '0;
      sximm8   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef ALU_SEQ_CYCLE_CNT_EN
      busy_cycles <= '0;
`endif
    end else begin
      state    <= state_n;
      ir       <= ir_n;
      in_ready <= ready_n;
      nsel     <= nsel_n;
      loada    <= loada_n;
      loadb    <= loadb_n;
      asel     <= asel_n;
      loadc    <= loadc_n;
      loads    <= loads_n;
      write    <= write_n;
      vsel     <= vsel_n;
      alu_op   <= alu_op_n;
      shift    <= shift_n;
      sximm8   <= sx_n;
      done     <= done_n;
      err      <= err_n;
`ifdef ALU_SEQ_CYCLE_CNT_EN
      if (state != S_IDLE && busy_cycles != '1)
        busy_cycles <= busy_cycles + 16'd1;
`endif
    end
  end

endmodule
